// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver with a per-frame BCD latch.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int DP_DIGIT    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic [15:0] digits_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int            CW       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [1:0]    DP_IDX   = 2'(DP_DIGIT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   lat_q, lat_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          frame_start;
  logic [3:0]    nib_w [4];
  logic [3:0]    nib_sel;
  logic [6:0]    glyph;
  logic          lead_zero;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] r;
    r = 7'b0111111;
    case (v)
      4'd0: r = 7'b1000000;
      4'd1: r = 7'b1111001;
      4'd2: r = 7'b0100100;
      4'd3: r = 7'b0110000;
      4'd4: r = 7'b0011001;
      4'd5: r = 7'b0010010;
      4'd6: r = 7'b0000010;
      4'd7: r = 7'b1111000;
      4'd8: r = 7'b0000000;
      4'd9: r = 7'b0010000;
      default: r = 7'b0111111;
    endcase
    return r;
  endfunction

  // Scan counters and frame latch.
  always_comb begin
    frame_start = (cnt_q == '0) && (idx_q == 2'd0);
    lat_d       = frame_start ? digits_in : lat_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    if (!enable) begin
      cnt_d = '0;
      idx_d = 2'd0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Decode from the latch's next value so the first digit of a frame
  // already shows the freshly captured data rather than the old frame.
  for (genvar gi = 0; gi < 4; gi++) begin : g_nib
    assign nib_w[gi] = lat_d[4*gi +: 4];
  end

  assign nib_sel = nib_w[idx_q];
  assign glyph   = decode(nib_sel);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  always_comb begin
    lead_zero = 1'b0;
    case (idx_q)
      2'd3:    lead_zero = (lat_d[15:12] == 4'd0);
      2'd2:    lead_zero = (lat_d[15:8]  == 8'd0);
      2'd1:    lead_zero = (lat_d[15:4]  == 12'd0);
      default: lead_zero = 1'b0;
    endcase
  end
`else
  assign lead_zero = 1'b0;
`endif

  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (enable) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = lead_zero ? 7'b1111111 : glyph;
      dp_d  = (idx_q != DP_IDX);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
      lat_q <= 16'h0000;
      an_q  <= 4'b1111;
      seg_q <= 7'b1111111;
      dp_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      lat_q <= lat_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: elapsed-time reference model plus literal checks.
module tb_seg7_scan_driver;
  localparam int DIV = 4;
  localparam int DPD = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic [15:0] digits_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.REFRESH_DIV(DIV), .DP_DIGIT(DPD)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .digits_in(digits_in),
    .an(an), .seg(seg), .dp(dp)
  );

  function automatic logic [6:0] glyph_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Model: t = cycles elapsed since scanning (re)started; digit = (t/DIV)%4,
  // a new frame is latched whenever t is a multiple of 4*DIV.
  int          t = 0;
  logic [15:0] m_lat = 16'h0000;
  logic [3:0]  m_an = 4'b1111;
  logic [6:0]  m_seg = 7'b1111111;
  logic        m_dp = 1'b1;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      t = 0; m_lat = 16'h0000; m_an = 4'b1111; m_seg = 7'b1111111; m_dp = 1'b1;
    end else begin : upd
      int d;
      logic [15:0] shown;
      shown = (t % (4*DIV) == 0) ? digits_in : m_lat;
      d = (t / DIV) % 4;
      if (enable) begin
        m_an  = 4'b1111 ^ (4'b0001 << d);
        m_seg = glyph_of(shown[4*d +: 4]);
        m_dp  = (d != DPD);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (d > 0 && (shown >> (4*d)) == 16'd0) m_seg = 7'b1111111;
`endif
      end else begin
        m_an = 4'b1111; m_seg = 7'b1111111; m_dp = 1'b1;
      end
      m_lat = shown;
      t = enable ? t + 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if (an !== m_an || seg !== m_seg || dp !== m_dp) begin
        errors++;
        $display("FAIL model_cmp @%0t: an=%b seg=%b dp=%b required an=%b seg=%b dp=%b",
                 $time, an, seg, dp, m_an, m_seg, m_dp);
      end
    end
  end

  logic [3:0] an_tab [4]   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] s1234  [4]   = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [3:0] ea, input logic [6:0] es, input logic ed);
    checks++;
    if (an !== ea || seg !== es || dp !== ed) begin
      errors++;
      $display("FAIL %s @%0t: an=%b seg=%b dp=%b required an=%b seg=%b dp=%b",
               name, $time, an, seg, dp, ea, es, ed);
    end
  endtask

  task automatic lit_scan(input string name, input int k, input logic [6:0] es);
    lit(name, an_tab[(k/4)%4], es, ((k/4)%4 == 2) ? 1'b0 : 1'b1);
  endtask

  initial begin
    logic [6:0] es;
    resetn = 1'b1; enable = 1'b0; digits_in = 16'h1234;
    #2 resetn = 1'b0;
    #1 lit("reset_state", 4'b1111, 7'b1111111, 1'b1);
    chk_on = 1'b1;
    tick(); tick();
    resetn = 1'b1;

    // Blank while disabled
    for (int i = 0; i < 20; i++) begin
      tick();
      lit("blank_disabled", 4'b1111, 7'b1111111, 1'b1);
    end

    // Scan order with 1234
    enable = 1'b1;
    for (int k = 0; k < 32; k++) begin
      tick();
      lit_scan("scan_1234", k, s1234[(k/4)%4]);
    end

    // Tear-free latch: 0000 -> 9999 while digit 1 is lit
    enable = 1'b0; digits_in = 16'h0000;
    tick(); tick();
    enable = 1'b1;
    for (int k = 0; k < 32; k++) begin
      tick();
      es = (k < 16) ? 7'b1000000 : 7'b0010000;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (k >= 4 && k < 16) es = 7'b1111111;
`endif
      lit_scan("tear_free", k, es);
      if (k == 4) digits_in = 16'h9999;
    end

    // Non-BCD nibble on digit 1
    enable = 1'b0; digits_in = 16'h00A0;
    tick();
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      lit_scan("non_bcd", k, (k < 4) ? 7'b1000000 : 7'b0111111);
    end

    // Asynchronous reset while digit 2 is lit
    tick(); tick();
    #1 resetn = 1'b0;
    #1 lit("reset_async", 4'b1111, 7'b1111111, 1'b1);
    tick();
    resetn = 1'b1; enable = 1'b1; digits_in = 16'h1234;
    for (int k = 0; k < 8; k++) begin
      tick();
      lit_scan("resume_after_reset", k, s1234[(k/4)%4]);
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    enable = 1'b0; digits_in = 16'h0005;
    tick();
    enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k < 4)       es = 7'b0010010;
      else if (k < 16) es = 7'b1111111;
      else             es = 7'b1000000;
      lit_scan("lead_zero", k, es);
      if (k == 5) digits_in = 16'h0000;
    end
`endif

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 1500; i++) begin
      tick();
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 9) == 0) digits_in = 16'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        resetn = 1'b0;
        #2 resetn = 1'b1;
      end
    end

    tick();
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
